// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC register and the IF/ID, ID/EX, EX/MEM, MEM/WB
// pipeline registers of the 5-stage MIPS core, with per-stage valid bits.
// Stall/flush requests come from the hazard unit.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_regs #(
    parameter int              DW       = 32,
    parameter int              CW       = 8,
    parameter logic [DW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          FlushE,
    input  logic [DW-1:0] PCNextF,
    output logic [DW-1:0] PCF,
    input  logic [DW-1:0] InstrF,
    input  logic [DW-1:0] PCPlus4F,
    output logic [DW-1:0] InstrD,
    output logic [DW-1:0] PCPlus4D,
    input  logic [CW-1:0] CtrlD,
    input  logic [DW-1:0] RD1D,
    input  logic [DW-1:0] RD2D,
    input  logic [DW-1:0] SignImmD,
    input  logic [4:0]    RsD,
    input  logic [4:0]    RtD,
    input  logic [4:0]    RdD,
    output logic [CW-1:0] CtrlE,
    output logic [DW-1:0] RD1E,
    output logic [DW-1:0] RD2E,
    output logic [DW-1:0] SignImmE,
    output logic [4:0]    RsE,
    output logic [4:0]    RtE,
    output logic [4:0]    RdE,
    input  logic          RegWriteE2,
    input  logic          MemToRegE2,
    input  logic          MemWriteE2,
    input  logic [DW-1:0] ALUOutE,
    input  logic [DW-1:0] WriteDataE,
    input  logic [4:0]    WriteRegE,
    output logic          RegWriteM,
    output logic          MemToRegM,
    output logic          MemWriteM,
    output logic [DW-1:0] ALUOutM,
    output logic [DW-1:0] WriteDataM,
    output logic [4:0]    WriteRegM,
    input  logic [DW-1:0] ReadDataM,
    output logic          RegWriteW,
    output logic          MemToRegW,
    output logic [DW-1:0] ReadDataW,
    output logic [DW-1:0] ALUOutW,
    output logic [4:0]    WriteRegW,
    output logic          ValidD,
    output logic          ValidE,
    output logic          ValidM,
    output logic          ValidW
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]   StallCnt,
    output logic [31:0]   FlushCnt,
    output logic [31:0]   RetireCnt
`endif
);

    logic [DW-1:0] pcF_q, pcF_d;
    logic [DW-1:0] instrD_q, instrD_d, pcPlus4D_q, pcPlus4D_d;
    logic          validD_q, validD_d;
    logic [CW-1:0] ctrlE_q, ctrlE_d;
    logic [DW-1:0] rd1E_q, rd1E_d, rd2E_q, rd2E_d, signImmE_q, signImmE_d;
    logic [4:0]    rsE_q, rsE_d, rtE_q, rtE_d, rdE_q, rdE_d;
    logic          validE_q, validE_d;
    logic          regWriteM_q, regWriteM_d, memToRegM_q, memToRegM_d;
    logic          memWriteM_q, memWriteM_d, validM_q, validM_d;
    logic [DW-1:0] aluOutM_q, aluOutM_d, writeDataM_q, writeDataM_d;
    logic [4:0]    writeRegM_q, writeRegM_d;
    logic          regWriteW_q, regWriteW_d, memToRegW_q, memToRegW_d;
    logic          validW_q, validW_d;
    logic [DW-1:0] readDataW_q, readDataW_d, aluOutW_q, aluOutW_d;
    logic [4:0]    writeRegW_q, writeRegW_d;

    // Fetch PC advances unless the hazard unit freezes fetch.
    always_comb begin
        pcF_d = StallF ? pcF_q : PCNextF;
    end

    // IF/ID: a stall outranks a flush so a held instruction is never lost.
    always_comb begin
        instrD_d   = instrD_q;
        pcPlus4D_d = pcPlus4D_q;
        validD_d   = validD_q;
        if (!StallD) begin
            if (FlushD) begin
                instrD_d   = '0;
                pcPlus4D_d = '0;
                validD_d   = 1'b0;
            end else begin
                instrD_d   = InstrF;
                pcPlus4D_d = PCPlus4F;
                validD_d   = 1'b1;
            end
        end
    end

    // ID/EX: a flush or a stalled decode stage injects a bubble with no control.
    always_comb begin
        validE_d   = 1'b0;
        ctrlE_d    = '0;
        rd1E_d     = '0;
        rd2E_d     = '0;
        signImmE_d = '0;
        rsE_d      = '0;
        rtE_d      = '0;
        rdE_d      = '0;
        if (!FlushE) begin
            validE_d   = validD_q & ~StallD;
            ctrlE_d    = validE_d ? CtrlD : '0;
            rd1E_d     = RD1D;
            rd2E_d     = RD2D;
            signImmE_d = SignImmD;
            rsE_d      = RsD;
            rtE_d      = RtD;
            rdE_d      = RdD;
        end
    end

    // EX/MEM and MEM/WB always advance; write enables are qualified by validity.
    always_comb begin
        validM_d     = validE_q;
        regWriteM_d  = RegWriteE2 & validE_q;
        memWriteM_d  = MemWriteE2 & validE_q;
        memToRegM_d  = MemToRegE2;
        aluOutM_d    = ALUOutE;
        writeDataM_d = WriteDataE;
        writeRegM_d  = WriteRegE;
        validW_d     = validM_q;
        regWriteW_d  = regWriteM_q & validM_q;
        memToRegW_d  = memToRegM_q;
        readDataW_d  = ReadDataM;
        aluOutW_d    = aluOutM_q;
        writeRegW_d  = writeRegM_q;
    end

    // All stage-boundary state, cleared asynchronously so nothing in flight survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcF_q        <= RESET_PC;
            instrD_q     <= '0;
            pcPlus4D_q   <= '0;
            validD_q     <= 1'b0;
            ctrlE_q      <= '0;
            rd1E_q       <= '0;
            rd2E_q       <= '0;
            signImmE_q   <= '0;
            rsE_q        <= '0;
            rtE_q        <= '0;
            rdE_q        <= '0;
            validE_q     <= 1'b0;
            regWriteM_q  <= 1'b0;
            memToRegM_q  <= 1'b0;
            memWriteM_q  <= 1'b0;
            validM_q     <= 1'b0;
            aluOutM_q    <= '0;
            writeDataM_q <= '0;
            writeRegM_q  <= '0;
            regWriteW_q  <= 1'b0;
            memToRegW_q  <= 1'b0;
            validW_q     <= 1'b0;
            readDataW_q  <= '0;
            aluOutW_q    <= '0;
            writeRegW_q  <= '0;
        end else begin
            pcF_q        <= pcF_d;
            instrD_q     <= instrD_d;
            pcPlus4D_q   <= pcPlus4D_d;
            validD_q     <= validD_d;
            ctrlE_q      <= ctrlE_d;
            rd1E_q       <= rd1E_d;
            rd2E_q       <= rd2E_d;
            signImmE_q   <= signImmE_d;
            rsE_q        <= rsE_d;
            rtE_q        <= rtE_d;
            rdE_q        <= rdE_d;
            validE_q     <= validE_d;
            regWriteM_q  <= regWriteM_d;
            memToRegM_q  <= memToRegM_d;
            memWriteM_q  <= memWriteM_d;
            validM_q     <= validM_d;
            aluOutM_q    <= aluOutM_d;
            writeDataM_q <= writeDataM_d;
            writeRegM_q  <= writeRegM_d;
            regWriteW_q  <= regWriteW_d;
            memToRegW_q  <= memToRegW_d;
            validW_q     <= validW_d;
            readDataW_q  <= readDataW_d;
            aluOutW_q    <= aluOutW_d;
            writeRegW_q  <= writeRegW_d;
        end
    end

    assign PCF        = pcF_q;
    assign InstrD     = instrD_q;
    assign PCPlus4D   = pcPlus4D_q;
    assign ValidD     = validD_q;
    assign CtrlE      = ctrlE_q;
    assign RD1E       = rd1E_q;
    assign RD2E       = rd2E_q;
    assign SignImmE   = signImmE_q;
    assign RsE        = rsE_q;
    assign RtE        = rtE_q;
    assign RdE        = rdE_q;
    assign ValidE     = validE_q;
    assign RegWriteM  = regWriteM_q;
    assign MemToRegM  = memToRegM_q;
    assign MemWriteM  = memWriteM_q;
    assign ALUOutM    = aluOutM_q;
    assign WriteDataM = writeDataM_q;
    assign WriteRegM  = writeRegM_q;
    assign ValidM     = validM_q;
    assign RegWriteW  = regWriteW_q;
    assign MemToRegW  = memToRegW_q;
    assign ReadDataW  = readDataW_q;
    assign ALUOutW    = aluOutW_q;
    assign WriteRegW  = writeRegW_q;
    assign ValidW     = validW_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stallCnt_q, flushCnt_q, retireCnt_q;

    // Free-running event counters: decode stalls, effective decode flushes, retirements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
            retireCnt_q <= '0;
        end else begin
            if (StallD)           stallCnt_q  <= stallCnt_q + 32'd1;
            if (FlushD && !StallD) flushCnt_q <= flushCnt_q + 32'd1;
            if (validW_q)         retireCnt_q <= retireCnt_q + 32'd1;
        end
    end

    assign StallCnt  = stallCnt_q;
    assign FlushCnt  = flushCnt_q;
    assign RetireCnt = retireCnt_q;
`endif

endmodule
